// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: tracks in-flight fetch predictions in order, checks them at memory-stage
// resolve, and emits predictor updates, pipeline flush/redirect and branch statistics.
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_valid,
    input  logic [31:0]      fetch_pc,
    input  logic             fetch_pred_taken,
    input  logic [31:0]      fetch_pred_target,
    input  logic             res_valid,
    input  logic             res_branch,
    input  logic             res_taken,
    input  logic [31:0]      res_target,
    output logic             upd_valid,
    output logic [31:0]      upd_pc,
    output logic             upd_taken,
    output logic [31:0]      upd_target,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count,
    output logic             err_overflow,
    output logic             err_underflow
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic        predTaken;
        logic [31:0] predTarget;
    } queueEntry_t;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t          state;
    queueEntry_t     queueMem [DEPTH];
    queueEntry_t     headEntry;
    logic [PTR_W-1:0] headPtr, tailPtr;
    logic [OCC_W-1:0] occupancy;

    logic inRun, isEmpty, isFull;
    logic doPop, doPush, mispredict, underflow, overflow;

    assign inRun     = (state == RUN);
    assign isEmpty   = (occupancy == '0);
    assign isFull    = (occupancy == OCC_W'(DEPTH));
    assign headEntry = queueMem[headPtr];

    assign doPop      = inRun & res_valid & ~isEmpty;
    assign underflow  = inRun & res_valid & isEmpty;
    assign mispredict = doPop & (res_branch
                          ? ((res_taken != headEntry.predTaken) ||
                             (res_taken & headEntry.predTaken & (res_target != headEntry.predTarget)))
                          : headEntry.predTaken);
    // A push racing a mispredict is wrong-path work and is dropped along with the queue.
    assign doPush     = inRun & fetch_valid & ~mispredict & (~isFull | doPop);
    assign overflow   = inRun & fetch_valid & isFull & ~doPop;

    // NOTE: entry storage is deliberately not reset; occupancy alone says which slots are live.
    always_ff @(posedge clk) begin
        if (doPush) begin
            queueMem[tailPtr] <= '{pc: fetch_pc, predTaken: fetch_pred_taken,
                                   predTarget: fetch_pred_target};
        end
    end

    // NOTE: every register here is state, so only non-blocking assignments are used.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= RUN;
            headPtr          <= '0;
            tailPtr          <= '0;
            occupancy        <= '0;
            upd_valid        <= 1'b0;
            upd_pc           <= '0;
            upd_taken        <= 1'b0;
            upd_target       <= '0;
            flush            <= 1'b0;
            redirect_pc      <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
            err_overflow     <= 1'b0;
            err_underflow    <= 1'b0;
        end else begin
            upd_valid <= 1'b0;
            if (state == FLUSH) begin
                state <= RUN;
                flush <= 1'b0;
            end else begin
                flush <= mispredict;
                if (doPop) begin
                    upd_valid  <= res_branch;
                    upd_pc     <= headEntry.pc;
                    upd_taken  <= res_taken;
                    upd_target <= res_target;
                    if (res_branch && branch_count != '1)
                        branch_count <= branch_count + CNT_W'(1);
                    if (mispredict && mispredict_count != '1)
                        mispredict_count <= mispredict_count + CNT_W'(1);
                end
                if (mispredict) begin
                    state       <= FLUSH;
                    redirect_pc <= res_taken ? res_target : headEntry.pc + 32'd4;
                    headPtr     <= '0;
                    tailPtr     <= '0;
                    occupancy   <= '0;
                end else begin
                    if (doPop)
                        headPtr <= headPtr + PTR_W'(1);
                    if (doPush)
                        tailPtr <= tailPtr + PTR_W'(1);
                    if (doPush && !doPop)
                        occupancy <= occupancy + OCC_W'(1);
                    else if (doPop && !doPush)
                        occupancy <= occupancy - OCC_W'(1);
                end
                if (underflow)
                    err_underflow <= 1'b1;
                if (overflow)
                    err_overflow <= 1'b1;
            end
        end
    end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Producer side of the branch-prediction interface. It records each fetch-stage prediction in an in-order tracking queue.
- When the instruction resolves in the memory stage, it compares the actual outcome with the prediction.
- It then sends a registered update packet to the predictor (resolved / taken / PC / target) and drives a one-cycle pipeline flush with the redirect PC on any misprediction.
- It sits between the fetch stage, the memory-stage resolve logic and the branch predictor. It also keeps branch and misprediction counters.

Parameters:
- DEPTH, 4, tracking-queue entries (≥ number of in-flight instructions fetch→memory); power of two.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- fetch_valid  input  1  fetch issued an instruction this cycle; push prediction
- fetch_pc  input  32  PC of the fetched instruction
- fetch_pred_taken  input  1  predictor said taken
- fetch_pred_target  input  32  predicted next PC when taken
- res_valid  input  1  oldest in-flight instruction resolves this cycle; pop
- res_branch  input  1  resolving instruction is a branch
- res_taken  input  1  actual branch outcome (condition passed)
- res_target  input  32  actual branch target (ALU result)
- upd_valid  output  1  update packet valid (resolved branch)
- upd_pc  output  32  PC of the resolved branch
- upd_taken  output  1  actual outcome
- upd_target  output  32  actual target
- flush  output  1  one-cycle flush of fetch/decode/execute
- redirect_pc  output  32  correct next PC, valid while flush=1
- branch_count  output  CNT_W  resolved branches
- mispredict_count  output  CNT_W  mispredictions
- err_overflow  output  1  sticky: push while full without pop
- err_underflow  output  1  sticky: pop while empty

Behaviour:
- Reset (async, any time including mid-flush): queue empty, FSM=RUN, all outputs 0, counters 0, sticky errors cleared.
- Queue entry holds {pc, pred_taken, pred_target}. Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. Occupancy counter runs 0..DEPTH.
- FSM RUN:
  - push when fetch_valid; pop when res_valid.
  - Simultaneous push+pop is legal at any occupancy, including full; occupancy stays unchanged.
- Head entry H is compared against the resolve inputs, combinationally on pop. Mispredict when any of:
  - res_branch & (res_taken ≠ H.pred_taken);
  - res_branch & res_taken & H.pred_taken & (res_target ≠ H.pred_target);
  - !res_branch & H.pred_taken.
- Registered outputs, latency 1 cycle after a res_valid cycle:
  - upd_valid = res_branch; upd_pc = H.pc; upd_taken = res_taken; upd_target = res_target.
  - upd_valid is a one-cycle pulse.
- On mispredict at edge t+1:
  - FSM→FLUSH; flush=1; redirect_pc = res_taken ? res_target : H.pc+4 (32-bit, wraps).
  - Entire queue cleared; a same-cycle push is discarded (wrong path).
- FSM FLUSH, exactly 1 cycle:
  - fetch_valid and res_valid ignored (no push/pop, no update, no errors).
  - Next edge: FLUSH→RUN, flush=0, redirect_pc held.
- Counters:
  - branch_count +1 per popped res_branch=1.
  - mispredict_count +1 per mispredict.
  - Both saturate at all-ones.
- Pop while empty (RUN): err_underflow set; no update, no flush, no count change.
- Push while full and no pop: err_overflow set; entry dropped; queue unchanged.
- Correct prediction: no flush; queue continues in order.

Test Plan:
- Correct not-taken: push pc=0x10, pred_taken=0; pop with res_branch=1, res_taken=0 → next cycle upd_valid=1, upd_pc=0x10, upd_taken=0; flush=0; branch_count=1, mispredict_count=0.
- Direction mispredict with flush: push 0x20 (pred 0), 0x24, 0x28; pop with res_branch=1, res_taken=1, res_target=0x80 → flush=1 for exactly one cycle, redirect_pc=0x80, occupancy=0, mispredict_count=1; fetch_valid during FLUSH is not queued.
- Target mispredict and non-branch predicted taken:
  - 0x30 pred taken to 0x40, actual taken to 0x44 → redirect 0x44.
  - Non-branch 0x50 pred taken → redirect 0x54, upd_valid=0.
- Full queue: DEPTH=4 pushes 0x0..0xC, then push+pop in the same cycle → no error, occupancy 4. Then push with no pop → err_overflow=1, queue still 0x4..0x10 in order.
- Empty pop → err_underflow=1, no update pulse. Then assert reset mid-FLUSH → flush, errors, counters immediately 0 and FSM=RUN.
- Counter saturation: CNT_W=2, four correct branches → branch_count holds 3.
